uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised, buffered serial transmitter that replaces the single-byte, fire-and-forget UART path behind the store-to-UART_ADDR decode in the CPU top. Stores write bytes into a FIFO and a frame FSM drains it. The FSM supports configurable data width, parity and stop bits. Status outputs (full/empty/count/overflow) let software poll for space instead of losing characters.

Parameters:
CLKS_PER_BIT, 868, clk cycles per serial bit (>=2).
DATA_BITS, 8, payload bits per frame (5..8).
FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.

Ports:
clk  in  1  system clock
rst  in  1  reset
wr_en  in  1  push request (store to UART data address)
wr_data  in  DATA_BITS  byte to push
clr_ovf  in  1  clears the sticky overflow flag
tx  out  1  serial line, idle high
busy  out  1  frame in progress
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
count  out  $clog2(FIFO_DEPTH)+1  occupied entries
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset rst: synchronous, active-high. Clock clk.
- Reset values: tx=1, busy=0, full=0, empty=1, count=0, overflow=0. FIFO pointers and FSM return to IDLE.
- Reset mid-frame: the frame is aborted and tx=1 from the next edge. FIFO contents are discarded.
- Push: on wr_en && !full, wr_data is written at the write pointer. count increments on the next edge.
- Push while full is dropped and overflow is set. This holds even if a pop occurs in the same cycle, because full is the registered value.
- Overflow flag: clr_ovf clears it. If clr_ovf and a dropped push occur in the same cycle, set wins.
- Pointers: wrap modulo FIFO_DEPTH. count is the registered occupancy. Simultaneous push and pop leave count unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: tx=1, busy=0. If !empty, pop the head into the shift register, load the parity accumulator, go to START. busy=1 from the next edge.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shift LSB first. Each bit lasts CLKS_PER_BIT cycles. Bit counter runs 0..DATA_BITS-1. Then go to PAR if PARITY!=0, else STOP.
- PAR: even mode sends XOR of the data bits. Odd mode sends its inverse. Duration CLKS_PER_BIT.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- End of STOP, FIFO not empty: pop immediately and go to START, so back-to-back frames have no idle gap.
- End of STOP, FIFO empty: go to IDLE.
- Baud counter: runs 0..CLKS_PER_BIT-1 and reloads on each bit boundary.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Latency: push in cycle N -> count=1 at N+1. FSM pops at N+1 -> tx=0 from N+2. tx is registered (glitch-free).
- wr_data bits above DATA_BITS are not applicable. The CPU top passes the low DATA_BITS of the store value.
- Illegal parameter values (PARITY>2, STOP_BITS not 1/2, non-power-of-two depth): elaboration-time $error.

Decomposition:
- Shared package uart_pkg: PARITY_NONE/ODD/EVEN constants, FSM state encoding, UART_DATA_ADDR/UART_STAT_ADDR constants. Status word layout: bit0 full, bit1 empty, bit2 overflow, bit3 busy, bits[15:8] count.
- Sub-module sync_fifo (parametrised width/depth, registered count/full/empty) instantiated once.
- The frame FSM stays in uart_tx_fifo.

Test Plan:
1. CLKS_PER_BIT=4, 8N1, push 0x55 at cycle 10. Expect tx=0 over cycles 12-15. Then data bits 1,0,1,0,1,0,1,0 at 4 cycles each. Then stop high over 48-51. busy=1 over 12-51, total 40 cycles.
2. 8E1, push 0x07. Expect parity bit 1 and frame length 44 cycles. With 8O1 the parity bit is 0.
3. FIFO_DEPTH=4, idle FSM held off by pushing 6 bytes in 6 consecutive cycles. The first pop at cycle 2 makes the 6th push land on count=4 (full): expect full=1, 6th byte dropped, overflow=1. Line output is exactly bytes 1-5 in order. clr_ovf -> overflow=0 next cycle.
4. Push 0xA1, 0xB2 back-to-back, 8N2. Expect the second start bit on the cycle immediately after the 2-bit stop of the first frame, with no extra idle cycles.
5. Assert rst mid-DATA with 3 bytes queued. Next edge: tx=1, busy=0, empty=1, count=0. After deassert, tx stays high with no residual frame.
6. DATA_BITS=7, even parity, push 0x7F. Expect 7 ones, parity 1, frame of 10 bits.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, frame FSM encoding, CPU address map
// and the status word layout read back by software.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0004;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } tx_state_t;

    // Status word: bit0 full, bit1 empty, bit2 overflow, bit3 busy, [15:8] count.
    function automatic logic [15:0] uart_status(input logic       full,
                                                input logic       empty,
                                                input logic       overflow,
                                                input logic       busy,
                                                input logic [7:0] count);
        return {count, 4'b0000, busy, overflow, empty, full};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and registered
// count/full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [CNT_W-1:0] w_count_next;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_count_next = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_MAX);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: CPU stores fill a FIFO, the frame FSM drains it
// with configurable data width, parity and stop bits; tx is registered.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = 3;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_chk_cpb
        $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_data
        $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if ((PARITY < 0) || (PARITY > 2)) begin : g_chk_par
        $error("uart_tx_fifo: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [BAUD_W-1:0]     r_baud;
    logic [BAUD_W-1:0]     w_baud_next;
    logic [BIT_W-1:0]      r_bit;
    logic [BIT_W-1:0]      w_bit_next;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  w_shift_next;
    logic                  r_parity;
    logic                  w_parity_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_overflow;
    logic                  w_bit_end;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_full;
    logic                  w_empty;
    logic [DATA_BITS-1:0]  w_head;

    // Full is the registered flag, so a push in a full cycle drops even if a pop frees a slot.
    assign w_push    = wr_en && !w_full;
    assign w_bit_end = (r_baud == BAUD_LAST);

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_baud   <= w_baud_next;
            r_bit    <= w_bit_next;
            r_shift  <= w_shift_next;
            r_parity <= w_parity_next;
            r_tx     <= w_tx_next;
            r_busy   <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_shift_next  = r_shift;
        w_parity_next = r_parity;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit == DATA_LAST) begin
                        w_state_next = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        w_shift_next = r_shift >> 1;
                    end
                end
            end
            ST_PAR: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                // Chaining straight into START keeps back-to-back frames gap-free.
                if (w_bit_end && (r_bit == STOP_LAST)) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_pop) begin
            w_shift_next  = w_head;
            w_parity_next = ^w_head;
        end

        w_baud_next = ((r_state == ST_IDLE) || w_bit_end) ? '0 : r_baud + 1'b1;
        if (w_state_next != r_state) begin
            w_bit_next = '0;
        end else if (w_bit_end) begin
            w_bit_next = r_bit + 1'b1;
        end else begin
            w_bit_next = r_bit;
        end
    end

    // Line level is decided from the next state so the registered tx lines up with it.
    always_comb begin
        w_busy_next = (w_state_next != ST_IDLE);
        case (w_state_next)
            ST_START: w_tx_next = 1'b0;
            ST_DATA:  w_tx_next = w_shift_next[0];
            ST_PAR:   w_tx_next = (PARITY == PARITY_EVEN) ? w_parity_next : ~w_parity_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule
